// File: rtl/cv32e40p_x_pkg.sv
// Shared x-interface types: result entry layout and default result-buffer depth.
// Data width of x_result_t is the default; wider builds use a matching local struct.
package cv32e40p_x_pkg;

  localparam int unsigned X_RESULT_DEPTH = 4;
  localparam int unsigned X_DATA_WIDTH   = 32;

  typedef struct packed {
    logic [4:0]              rd;
    logic                    we;
    logic [X_DATA_WIDTH-1:0] data;
  } x_result_t;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Generic pointer/count FIFO of result entries; head is visible combinationally, 1-cycle write-to-head.
// Backpressure: push ignored when full (pop-only), pop ignored when empty; reset clears all storage.
module cv32e40p_x_result_fifo
  import cv32e40p_x_pkg::*;
#(
  parameter int unsigned DEPTH = X_RESULT_DEPTH,
  parameter type         T     = x_result_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  T                           push_dat_i,
  input  logic                       pop_i,
  output T                           head_dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) begin
      mem_d[wptr_q] = push_dat_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_dat_o = empty_o ? '0 : mem_q[rptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/cv32e40p_x_result_buf.sv
// Queues coprocessor results in order and retires them into the regfile port when core writeback is idle.
// Ready depends only on occupancy; optional same-cycle bypass when empty: CV32E40P_X_RESULT_BYPASS_EN.
module cv32e40p_x_result_buf
  import cv32e40p_x_pkg::*;
#(
  parameter int unsigned DEPTH      = X_RESULT_DEPTH,
  parameter int unsigned DATA_WIDTH = X_DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    x_result_valid_i,
  output logic                    x_result_ready_o,
  input  logic [4:0]              x_result_rd_i,
  input  logic                    x_result_we_i,
  input  logic [DATA_WIDTH-1:0]   x_result_data_i,
  input  logic                    core_wb_busy_i,
  output logic                    regfile_we_o,
  output logic [4:0]              regfile_waddr_o,
  output logic [DATA_WIDTH-1:0]   regfile_wdata_o,
  output logic                    x_rvalid_o,
  output logic [4:0]              x_rwaddr_o,
  output logic [$clog2(DEPTH):0]  x_res_count_o
);

  // Same layout as x_result_t, sized to this instance's data width.
  typedef struct packed {
    logic [4:0]            rd;
    logic                  we;
    logic [DATA_WIDTH-1:0] data;
  } res_t;

  res_t in_res;
  res_t head_res;
  res_t ret_res;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic ret_vld;

  always_comb begin
    in_res      = '0;
    in_res.rd   = x_result_rd_i;
    in_res.we   = x_result_we_i;
    in_res.data = x_result_data_i;
  end

  assign x_result_ready_o = ~fifo_full;
  assign fifo_pop         = ~fifo_empty & ~core_wb_busy_i;

`ifdef CV32E40P_X_RESULT_BYPASS_EN
  logic byp_take;

  // An empty buffer hands a fresh result straight to the port instead of storing it.
  assign byp_take  = fifo_empty & x_result_valid_i & ~core_wb_busy_i & ~rst_i;
  assign fifo_push = x_result_valid_i & ~fifo_full & ~byp_take;
  assign ret_vld   = fifo_pop | byp_take;
  assign ret_res   = byp_take ? in_res : head_res;
`else
  assign fifo_push = x_result_valid_i & ~fifo_full;
  assign ret_vld   = fifo_pop;
  assign ret_res   = head_res;
`endif

  cv32e40p_x_result_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_dat_i (in_res),
    .pop_i      (fifo_pop),
    .head_dat_o (head_res),
    .count_o    (x_res_count_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // x0 still clears its scoreboard bit but never reaches the regfile.
  always_comb begin
    regfile_we_o    = 1'b0;
    regfile_waddr_o = '0;
    regfile_wdata_o = '0;
    x_rvalid_o      = 1'b0;
    x_rwaddr_o      = '0;
    if (ret_vld && ret_res.we) begin
      x_rvalid_o      = 1'b1;
      x_rwaddr_o      = ret_res.rd;
      regfile_we_o    = (ret_res.rd != 5'd0);
      regfile_waddr_o = ret_res.rd;
      regfile_wdata_o = ret_res.data;
    end
  end

endmodule

// File: tb/tb_cv32e40p_x_result_buf.sv
// Directed bench for the x-interface result buffer with hand-computed expectations.
module tb_cv32e40p_x_result_buf;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_result_valid_i;
  logic        x_result_ready_o;
  logic [4:0]  x_result_rd_i;
  logic        x_result_we_i;
  logic [31:0] x_result_data_i;
  logic        core_wb_busy_i;
  logic        regfile_we_o;
  logic [4:0]  regfile_waddr_o;
  logic [31:0] regfile_wdata_o;
  logic        x_rvalid_o;
  logic [4:0]  x_rwaddr_o;
  logic [2:0]  x_res_count_o;

  int n_vec = 0;
  int n_err = 0;

  cv32e40p_x_result_buf dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_rd_i    (x_result_rd_i),
    .x_result_we_i    (x_result_we_i),
    .x_result_data_i  (x_result_data_i),
    .core_wb_busy_i   (core_wb_busy_i),
    .regfile_we_o     (regfile_we_o),
    .regfile_waddr_o  (regfile_waddr_o),
    .regfile_wdata_o  (regfile_wdata_o),
    .x_rvalid_o       (x_rvalid_o),
    .x_rwaddr_o       (x_rwaddr_o),
    .x_res_count_o    (x_res_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [4:0] rd, input logic we, input logic [31:0] dat);
    x_result_valid_i = vld;
    x_result_rd_i    = rd;
    x_result_we_i    = we;
    x_result_data_i  = dat;
  endtask

  initial begin
    rst_i          = 1'b1;
    core_wb_busy_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #2;
    chk_vec("rst_count", 64'(x_res_count_o), 64'd0);
    chk_vec("rst_we", 64'(regfile_we_o), 64'd0);
    chk_vec("rst_rvalid", 64'(x_rvalid_o), 64'd0);
    chk_vec("rst_wdata", 64'(regfile_wdata_o), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk_vec("post_rst_ready", 64'(x_result_ready_o), 64'd1);
    chk_vec("post_rst_count", 64'(x_res_count_o), 64'd0);

    // Single result
    drive(1'b1, 5'd5, 1'b1, 32'hDEADBEEF);
    #1;
    chk_vec("single_ready", 64'(x_result_ready_o), 64'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    chk_vec("single_we", 64'(regfile_we_o), 64'd1);
    chk_vec("single_waddr", 64'(regfile_waddr_o), 64'd5);
    chk_vec("single_wdata", 64'(regfile_wdata_o), 64'hDEADBEEF);
    chk_vec("single_rvalid", 64'(x_rvalid_o), 64'd1);
    chk_vec("single_rwaddr", 64'(x_rwaddr_o), 64'd5);
    tick();
    chk_vec("single_count0", 64'(x_res_count_o), 64'd0);
    chk_vec("single_idle_rvalid", 64'(x_rvalid_o), 64'd0);

    // Fill while busy
    core_wb_busy_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 1'b1, 32'(i * 17));
      tick();
    end
    drive(1'b1, 5'd5, 1'b1, 32'd85);
    #1;
    chk_vec("full_ready", 64'(x_result_ready_o), 64'd0);
    chk_vec("full_count", 64'(x_res_count_o), 64'd4);
    chk_vec("busy_rvalid", 64'(x_rvalid_o), 64'd0);
    chk_vec("busy_we", 64'(regfile_we_o), 64'd0);
    tick();
    chk_vec("full_hold_count", 64'(x_res_count_o), 64'd4);
    core_wb_busy_i = 1'b0;
    #1;
    chk_vec("drain1_rwaddr", 64'(x_rwaddr_o), 64'd1);
    chk_vec("drain1_wdata", 64'(regfile_wdata_o), 64'd17);
    chk_vec("drain1_ready", 64'(x_result_ready_o), 64'd0);
    tick();
    chk_vec("drain2_rwaddr", 64'(x_rwaddr_o), 64'd2);
    chk_vec("drain2_ready", 64'(x_result_ready_o), 64'd1);
    chk_vec("drain2_count", 64'(x_res_count_o), 64'd3);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    chk_vec("drain3_rwaddr", 64'(x_rwaddr_o), 64'd3);
    chk_vec("drain3_count", 64'(x_res_count_o), 64'd3);
    tick();
    chk_vec("drain4_rwaddr", 64'(x_rwaddr_o), 64'd4);
    chk_vec("drain4_count", 64'(x_res_count_o), 64'd2);
    tick();
    chk_vec("drain5_rwaddr", 64'(x_rwaddr_o), 64'd5);
    chk_vec("drain5_wdata", 64'(regfile_wdata_o), 64'd85);
    chk_vec("drain5_count", 64'(x_res_count_o), 64'd1);
    tick();
    chk_vec("drained_count", 64'(x_res_count_o), 64'd0);
    chk_vec("drained_rvalid", 64'(x_rvalid_o), 64'd0);

    // Filtering: x0 write and non-writing result
    drive(1'b1, 5'd0, 1'b1, 32'hAA);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    chk_vec("x0_rvalid", 64'(x_rvalid_o), 64'd1);
    chk_vec("x0_rwaddr", 64'(x_rwaddr_o), 64'd0);
    chk_vec("x0_we", 64'(regfile_we_o), 64'd0);
    tick();
    drive(1'b1, 5'd7, 1'b0, 32'h77);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    chk_vec("nowe_count", 64'(x_res_count_o), 64'd1);
    chk_vec("nowe_rvalid", 64'(x_rvalid_o), 64'd0);
    chk_vec("nowe_we", 64'(regfile_we_o), 64'd0);
    tick();
    chk_vec("nowe_popped", 64'(x_res_count_o), 64'd0);

    // Streaming push+pop at count=2
    core_wb_busy_i = 1'b1;
    drive(1'b1, 5'd10, 1'b1, 32'd100);
    tick();
    drive(1'b1, 5'd11, 1'b1, 32'd101);
    tick();
    core_wb_busy_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(12 + i), 1'b1, 32'(102 + i));
      #1;
      chk_vec("stream_count", 64'(x_res_count_o), 64'd2);
      chk_vec("stream_wdata", 64'(regfile_wdata_o), 64'(100 + i));
      chk_vec("stream_rwaddr", 64'(x_rwaddr_o), 64'(10 + i));
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    chk_vec("stream_tail0", 64'(regfile_wdata_o), 64'd110);
    tick();
    chk_vec("stream_tail1", 64'(regfile_wdata_o), 64'd111);
    tick();
    chk_vec("stream_empty", 64'(x_res_count_o), 64'd0);

    // Reset mid-operation
    core_wb_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 1'b1, 32'(200 + i));
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    core_wb_busy_i = 1'b0;
    #1;
    chk_vec("prerst_count", 64'(x_res_count_o), 64'd3);
    chk_vec("prerst_rvalid", 64'(x_rvalid_o), 64'd1);
    #1;
    rst_i = 1'b1;
    #1;
    chk_vec("midrst_rvalid", 64'(x_rvalid_o), 64'd0);
    chk_vec("midrst_we", 64'(regfile_we_o), 64'd0);
    chk_vec("midrst_wdata", 64'(regfile_wdata_o), 64'd0);
    chk_vec("midrst_count", 64'(x_res_count_o), 64'd0);
    tick();
    rst_i = 1'b0;
    #1;
    chk_vec("afterrst_count", 64'(x_res_count_o), 64'd0);
    chk_vec("afterrst_ready", 64'(x_result_ready_o), 64'd1);
    chk_vec("afterrst_rvalid", 64'(x_rvalid_o), 64'd0);
    tick();
    chk_vec("nostale_rvalid", 64'(x_rvalid_o), 64'd0);
    chk_vec("nostale_count", 64'(x_res_count_o), 64'd0);

    // Empty-buffer result: same-cycle with bypass, next cycle without
    drive(1'b1, 5'd9, 1'b1, 32'h1234);
    #1;
`ifdef CV32E40P_X_RESULT_BYPASS_EN
    chk_vec("byp_we", 64'(regfile_we_o), 64'd1);
    chk_vec("byp_waddr", 64'(regfile_waddr_o), 64'd9);
    chk_vec("byp_rvalid", 64'(x_rvalid_o), 64'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    chk_vec("byp_count", 64'(x_res_count_o), 64'd0);
    chk_vec("byp_after_rvalid", 64'(x_rvalid_o), 64'd0);
`else
    chk_vec("nobyp_same_rvalid", 64'(x_rvalid_o), 64'd0);
    chk_vec("nobyp_same_we", 64'(regfile_we_o), 64'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    chk_vec("nobyp_next_we", 64'(regfile_we_o), 64'd1);
    chk_vec("nobyp_next_waddr", 64'(regfile_waddr_o), 64'd9);
    chk_vec("nobyp_next_wdata", 64'(regfile_wdata_o), 64'h1234);
    chk_vec("nobyp_next_count", 64'(x_res_count_o), 64'd1);
    tick();
    chk_vec("nobyp_drained", 64'(x_res_count_o), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_result_buf.md
# cv32e40p_x_result_buf

Result buffer sitting directly downstream of the x-interface dispatcher. Accepts results returned by the coprocessor over the x-interface result handshake and queues them in order. Retires each result into the core register-file write port whenever the core's own writeback does not occupy that port. Reports each retirement to the dispatcher (`x_rvalid`/`x_rwaddr`) so the dispatcher can clear the scoreboard bit for that register.

## Interface
Parameters:
- `DEPTH`, default 4: number of result entries; power of two, ≥2.
- `DATA_WIDTH`, default 32: result data width.

Ports:
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `x_result_valid_i` in 1: coprocessor offers a result.
- `x_result_ready_o` out 1: buffer accepts a result this cycle.
- `x_result_rd_i` in 5: destination register.
- `x_result_we_i` in 1: result carries a register write.
- `x_result_data_i` in DATA_WIDTH: result value.
- `core_wb_busy_i` in 1: core writeback uses the register-file port this cycle.
- `regfile_we_o` out 1: register-file write enable.
- `regfile_waddr_o` out 5: register-file write address.
- `regfile_wdata_o` out DATA_WIDTH: register-file write data.
- `x_rvalid_o` out 1: one-cycle retirement pulse to the dispatcher scoreboard.
- `x_rwaddr_o` out 5: register retired; valid only while `x_rvalid_o` is high.
- `x_res_count_o` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Push: `x_result_valid_i & x_result_ready_o`. The entry {rd, we, data} is written at the write pointer, and the pointer increments modulo DEPTH.
- `x_result_ready_o = (count != DEPTH)`. This is a registered-state function only. It has no combinational path from `core_wb_busy_i` or from a pop.
- Pop condition: head entry present and `~core_wb_busy_i`. The entry retires and the read pointer increments modulo DEPTH.
- On retire:
  - `x_rvalid_o=1` and `x_rwaddr_o=rd`, if the entry has `we=1`.
  - `regfile_we_o=1` only if `we=1` and `rd!=0`.
  - `regfile_waddr_o=rd` and `regfile_wdata_o=data`.
- Entries with `we=0` pop silently: no write, no `x_rvalid_o`.
- While `core_wb_busy_i=1`:
  - No pop occurs.
  - `regfile_we_o=0` and `x_rvalid_o=0`.
  - The head entry holds; pushes continue until full.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is allowed at any occupancy below DEPTH. When full, pop only.
- Order is strictly FIFO; there is no reordering or merging.
- Counter: `count_d = count_q + push - pop`. It never exceeds DEPTH and never underflows.
- Reset (at any time, including mid-operation) clears pointers, count, and every queued entry, all without a clock edge.
- Reset values:
  - `x_result_ready_o=1`, as soon as reset deasserts.
  - `regfile_we_o=0`, `regfile_waddr_o=0`, `regfile_wdata_o=0`.
  - `x_rvalid_o=0`, `x_rwaddr_o=0`.
  - `x_res_count_o=0`.
- Outputs are driven combinationally from head-entry state; idle values are 0.

## Timing
- Latency without bypass: a result accepted at edge N is retired in cycle N+1 if `core_wb_busy_i=0`. It is delayed by one cycle for each busy cycle.
- Throughput: one push and one pop per cycle.
- Full recovery: a pop from full raises `x_result_ready_o` in the following cycle.
- With bypass (see Configuration), latency is 0 cycles.

## Configuration
- `CV32E40P_X_RESULT_BYPASS_EN` defined:
  - If count==0, `x_result_valid_i=1` and `core_wb_busy_i=0`, the incoming result drives the regfile outputs and `x_rvalid_o` in the same cycle.
  - It is consumed without entering storage; count stays 0.
- Not defined:
  - Every result passes through storage.
  - There is no combinational path from `x_result_*_i` to any output.

## Structure
- Shared package `cv32e40p_x_pkg` holds:
  - `x_result_t` (rd[4:0], we, data[DATA_WIDTH-1:0]).
  - The default depth constant `X_RESULT_DEPTH=4`.
- Sub-module `cv32e40p_x_result_fifo` is the generic pointer/count FIFO of `x_result_t`. The top level adds the pop arbitration, the rd==0/we filtering, and the bypass.

## Test plan
- Single result: push {rd=5, we=1, data=0xDEADBEEF}, busy=0.
  - Next cycle: `regfile_we_o=1`, `waddr=5`, `wdata=0xDEADBEEF`, `x_rvalid_o=1`, `x_rwaddr_o=5`.
  - Count returns to 0.
- Fill while busy: hold busy=1 and push rd=1..5.
  - After four accepts, `x_result_ready_o=0` and count=4; rd=5 is stalled.
  - Release busy: retirements rd=1,2,3,4 occur in consecutive cycles.
  - rd=5 is accepted the cycle after the first pop.
- Filtering:
  - rd=0, we=1: `x_rvalid_o=1`, `x_rwaddr_o=0`, `regfile_we_o=0`.
  - rd=7, we=0: no outputs asserted; the entry pops.
- Back-to-back push and pop at count=2 for 10 cycles: count stays 2, and data is retired in input order.
- Reset mid-operation: assert `rst_i` with count=3 between clock edges.
  - Outputs go to 0 immediately.
  - After deassert, count=0 and ready=1; no stale entry is retired.
- Bypass with macro defined: count=0, push {rd=9, we=1, data=0x1234}, busy=0.
  - Same cycle: `regfile_we_o=1`, `waddr=9`, `x_rvalid_o=1`.
  - Count remains 0.
  - With the macro undefined, the same stimulus retires one cycle later.
